sma_us_interp: RTL
==================

// Module: sma_us_interp
// PURPOSE
// - Upsampling companion to the 4-tap moving-average decimator: takes one signed sample
//   per input beat and emits 2**LOG2_L linearly interpolated samples per input beat.
// - Sits on the reconstruction side of the filter chain, between the decimated stream and
//   the full-rate consumer. Uses valid/ready handshakes on both sides.
// PARAMETERS
// - DATA_W  16  sample width, signed two's complement (in and out)
// - LOG2_L  2   log2 of interpolation factor L (L = 4 by default); LOG2_L >= 1
// PORTS
// - clk      in   1       clock; all state changes on posedge
// - rst      in   1       asynchronous reset, active-high
// - x        in   DATA_W  signed input sample
// - x_valid  in   1       input sample present
// - x_ready  out  1       block accepts x this cycle (transfer = x_valid & x_ready)
// - y        out  DATA_W  signed interpolated output sample
// - y_valid  out  1       y holds a valid sample
// - y_ready  in   1       consumer accepts y this cycle (transfer = y_valid & y_ready)
// BEHAVIOUR
// - Reset: one clock, clk; rst is asynchronous and active-high. Reset gives state=PRIME,
//   y_valid=0, y=0, acc=0, diff=0, x_prev=0, x_cur=0, phase=0. Reset mid-RUN discards
//   the pending burst; the next input after reset re-primes.
// - Registers: x_prev, x_cur (DATA_W), diff (DATA_W+1, x_cur-x_prev, exact),
//   acc (DATA_W+LOG2_L+1), phase (LOG2_L bits).
// - PRIME: x_ready=1, y_valid=0. On x transfer: x_prev<=x; go to WAIT. Produces no output.
// - WAIT: x_ready=1, y_valid=0. On x transfer: x_cur<=x; diff<=x-x_prev;
//   acc<=x_prev<<<LOG2_L; phase<=0; go to RUN.
// - RUN: y_valid=1, y=acc>>>LOG2_L (arithmetic). Output k of the burst is
//   floor((L*x_prev + k*(x_cur-x_prev))/L), for k=0..L-1.
//   - y transfer with phase<L-1: acc<=acc+diff; phase<=phase+1.
//   - y transfer with phase==L-1: x_prev<=x_cur. If x_valid in the same cycle, load the
//     new sample as in WAIT and stay in RUN. Otherwise go to WAIT.
//   - x_ready = y_ready & (phase==L-1). This combinational path gives full throughput
//     (L outputs per input with no bubble).
// - No y transfer: y and y_valid hold stable (AXI-style). x_ready=0 mid-burst.
// - Latency: first y of a burst is valid the cycle after the x transfer that starts it.
// - Output is always within [min(x_prev,x_cur), max(x_prev,x_cur)]; no overflow is
//   possible. diff covers the full -2**DATA_W+1 .. 2**DATA_W-1 span.
// - y is a slice of registered acc. There is no combinational path from x to y.
// CONFIGURATION
// - SMA_US_ROUND_EN defined: y = (acc + 2**(LOG2_L-1)) >>> LOG2_L (round half up).
//   The adder is sized so it cannot overflow, and the result stays within the endpoints.
// - SMA_US_ROUND_EN undefined (default): y = acc >>> LOG2_L (floor, toward -inf).
// TESTING (L=4, DATA_W=16, y_ready=1 unless stated)
// - Prime x=0, then x=8 -> y = 0,2,4,6 on 4 consecutive cycles; then x=16 accepted on the
//   4th output cycle -> next burst y = 8,10,12,14 with no bubble.
// - Prime 0, then x=-3 -> floor: y = 0,-1,-2,-3. With SMA_US_ROUND_EN: y = 0,-1,-1,-2.
// - Prime -32768, then x=32767 -> y = -32768,-16385,-1,16383. No wrap.
// - Hold y_ready=0 for 5 cycles at phase 1 -> y stays 2, y_valid stays 1, x_ready=0.
//   Burst resumes with 4,6 after release.
// - Burst completes with x_valid=0 -> WAIT, y_valid=0. A later x=24 restarts from
//   x_prev=16: y = 16,18,20,22.
// - Assert rst at phase 2 -> y_valid=0 and y=0 immediately. The next input primes only,
//   with no output until a second input arrives.

Source files
------------

// File: rtl/sma_us_interp.sv
// sma_us_interp: linear-interpolating upsampler, L = 2**LOG2_L outputs per input.
// Each pair of consecutive input samples (a, b) produces the burst
// floor((L*a + k*(b-a))/L), k = 0..L-1, on a valid/ready output stream.
// The very first input after reset only primes the interpolator.
// Optional feature macro: SMA_US_ROUND_EN (round half up instead of floor).
module sma_us_interp #(
  parameter int DATA_W = 16,
  parameter int LOG2_L = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  input  logic                     y_ready
);

  localparam int DW = DATA_W + 1;
  localparam int AW = DATA_W + LOG2_L + 1;

  typedef enum logic [1:0] {
    PRIME,
    WAIT,
    RUN
  } state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x_prev;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [DW-1:0]     diff;
  logic signed [AW-1:0]     acc;
  logic [LOG2_L-1:0]        phase;

  logic                     last_phase;
  logic                     x_fire;
  logic                     y_fire;
  logic signed [DATA_W-1:0] base;
  logic signed [DW-1:0]     new_diff;
  logic signed [AW-1:0]     new_acc;

  // Handshakes and the values a freshly accepted sample loads. The burst
  // starts from x_prev in WAIT, and from x_cur when a new sample chains
  // directly onto the last output of a running burst.
  always_comb begin
    last_phase = (phase == {LOG2_L{1'b1}});
    y_valid    = (state == RUN);
    x_ready    = (state != RUN) || (y_ready && last_phase);
    x_fire     = x_valid && x_ready;
    y_fire     = y_valid && y_ready;
    base       = (state == RUN) ? x_cur : x_prev;
    new_diff   = DW'(x) - DW'(base);
    new_acc    = AW'(base) <<< LOG2_L;
  end

`ifdef SMA_US_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (LOG2_L - 1);
  logic signed [AW-1:0] acc_rnd;

  // Round half up; acc has a spare headroom bit so adding HALF cannot wrap.
  always_comb begin
    acc_rnd = acc + HALF;
    y       = DATA_W'(acc_rnd >>> LOG2_L);
  end
`else
  // Floor toward -inf: the arithmetic shift of the scaled accumulator.
  always_comb begin
    y = DATA_W'(acc >>> LOG2_L);
  end
`endif

  // Controller and datapath: prime, wait for the second endpoint, then step
  // acc by diff once per accepted output until the burst wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PRIME;
      x_prev <= '0;
      x_cur  <= '0;
      diff   <= '0;
      acc    <= '0;
      phase  <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (x_fire) begin
            x_prev <= x;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (x_fire) begin
            x_cur <= x;
            diff  <= new_diff;
            acc   <= new_acc;
            phase <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (y_fire) begin
            if (!last_phase) begin
              acc   <= acc + AW'(diff);
              phase <= phase + LOG2_L'(1);
            end else begin
              x_prev <= x_cur;
              if (x_valid) begin
                x_cur <= x;
                diff  <= new_diff;
                acc   <= new_acc;
                phase <= '0;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule
